dps_link_scheduler: RTL and testbench
=====================================

Name: dps_link_scheduler

Overview:
- Shares one 24-wire DPS/FNS encoder between two data requesters on the same link, with round-robin arbitration.
- Drives the encoder input register and tracks in-flight words through the encoder's fixed latency.
- Buffers the returned codewords in a credit-protected FIFO and presents them, tagged with their source, on a valid/ready output toward the bus driver.

Parameters:
- DATA_W, `DBLEN24, width of the binary payload accepted by the encoder.
- ENC_LAT, 1, encoder latency in clock edges from enc_datain change to enc_codeout valid (>=1).
- FIFO_DEPTH, 4, codeword FIFO entries (power of 2, >=2).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when 0, no new grants; in-flight words still complete and drain.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  DATA_W  requester 0 payload (value < FNS25*2 range of the code).
- req0_ready  out  1  requester 0 word accepted this cycle when valid&ready.
- req1_valid  in  1  requester 1 has a word.
- req1_data  in  DATA_W  requester 1 payload.
- req1_ready  out  1  requester 1 word accepted this cycle when valid&ready.
- enc_datain  out  DATA_W  registered encoder input.
- enc_codeout  in  24  encoder output, valid ENC_LAT edges after enc_datain updates.
- code_valid  out  1  FIFO head valid.
- code_out  out  24  FIFO head codeword.
- code_src  out  1  source of code_out (0/1).
- code_ready  in  1  downstream consumes head when code_valid&code_ready.
- busy  out  1  any word in flight or in FIFO.

Behaviour:
- Reset: enc_datain=0, code_out=0, code_src=0, code_valid=0, busy=0, req*_ready=0, FIFO and in-flight tracking cleared, RR pointer = requester 0 preferred. Reset mid-operation discards all in-flight and buffered words, with no partial output.
- Credit: grant allowed only when enable=1 and (fifo_count + inflight_count) < FIFO_DEPTH. Both counts are registered state. A pop in the same cycle does not free credit until the next cycle.
- Arbitration (combinational from registered state and valids):
  - Only one req*_ready is high per cycle.
  - If both requesters are valid, grant goes to the one not granted last.
  - If one is valid, it is granted.
  - The RR pointer updates only on an accepted handshake.
  - ready may depend on valid. Requesters must hold valid/data stable until accepted.
- Issue: on the accepting edge, enc_datain <= granted data and a tag {valid=1, src} enters a shift pipe of ENC_LAT+1 stages. With no accept, enc_datain holds its value and a tag with valid=0 enters.
- Return: when the pipe tail is valid, enc_codeout and the tail src are written into the FIFO at that edge.
- Latency (ENC_LAT=1, empty FIFO): accept in cycle 0, enc_datain in cycle 1, enc_codeout in cycle 2, code_valid in cycle 3. In general, code_valid rises ENC_LAT+2 cycles after the accept cycle.
- Throughput: one word per cycle sustained when code_ready=1 and FIFO_DEPTH >= ENC_LAT+3. Otherwise throughput is credit-limited, with no overflow ever.
- FIFO:
  - Head is registered: code_out/code_src/code_valid come from the head entry.
  - Simultaneous write and pop keeps the count unchanged.
  - Write to a full FIFO is impossible by credit; the bench asserts this.
  - Pop of an empty FIFO is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Empty FIFO: code_valid=0, and code_out holds the last popped codeword so idle link wires do not toggle.
- inflight_count: +1 on accept, -1 on tail-valid write, unchanged on both together.
- busy = (inflight_count != 0) | (fifo_count != 0).
- enable deassert: takes effect on the same cycle for ready. Pipe and FIFO continue to drain.
- Ordering: codewords leave in exact acceptance order across both sources.

Test Plan:
- Single word: reset, then req0 sends data=5 with code_ready=1 → req0_ready in cycle 0; code_valid=1 in cycle 3 with code_out=encoder(5), code_src=0; busy drops the cycle after the pop.
- Contention: both valid for 6 cycles, data 1..6 / 11..16 → grants alternate 0,1,0,1…; outputs in order 1,11,2,12,3,13 with matching code_src.
- Backpressure: code_ready=0, req0 streaming → exactly FIFO_DEPTH=4 words accepted, then req0_ready stays 0. Release code_ready → 4 codewords drain and streaming resumes with no loss or duplication.
- Full credit edge: fifo_count=3, inflight=0, pop and accept requested in the same cycle → accept allowed (3<4). With fifo_count=4 plus a same-cycle pop → no grant that cycle, grant the next cycle.
- Enable/reset: drop enable with 2 words in flight → no new ready, 2 codewords still emitted. Assert reset with 3 words buffered → the next cycle code_valid=0, code_out=0, busy=0, and no stale word appears afterwards.
- Idle hold: after the last pop with code_out=encoder(7), keep the link idle 10 cycles → code_out remains encoder(7) and code_valid=0.

Source files
------------

// File: rtl/dps_link_scheduler_if.sv
// rtl/dps_link_scheduler_if.sv - requester, encoder and codeword link signals of the DPS link scheduler
`ifndef DBLEN24
`define DBLEN24 20
`endif

interface dps_link_scheduler_if #(
    parameter int DATA_W = `DBLEN24
) ();
    logic              enable;
    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic [DATA_W-1:0] enc_datain;
    logic [23:0]       enc_codeout;
    logic              code_valid;
    logic [23:0]       code_out;
    logic              code_src;
    logic              code_ready;
    logic              busy;

    modport master (
        input  enable, req0_valid, req0_data, req1_valid, req1_data, enc_codeout, code_ready,
        output req0_ready, req1_ready, enc_datain, code_valid, code_out, code_src, busy
    );

    modport slave (
        output enable, req0_valid, req0_data, req1_valid, req1_data, enc_codeout, code_ready,
        input  req0_ready, req1_ready, enc_datain, code_valid, code_out, code_src, busy
    );
endinterface

// File: rtl/dps_link_scheduler.sv
// rtl/dps_link_scheduler.sv - round-robin sharing of one DPS/FNS encoder between two requesters
// Tags track words through the encoder latency; codewords return through a credit-protected FIFO.

module dps_link_scheduler #(
    parameter int DATA_W     = `DBLEN24,
    parameter int ENC_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input logic                  clock,
    input logic                  reset,
    dps_link_scheduler_if.master bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PIPE_N = ENC_LAT + 1;

    logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  remain;
    logic [CNT_W:0]    credit_used;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [24:0]       mem_q [FIFO_DEPTH];
    logic [PIPE_N-1:0] tag_v_q, tag_s_q;
    logic              last_src_q;
    logic [DATA_W-1:0] enc_datain_q;
    logic [23:0]       head_code_q, head_code_d;
    logic              head_src_q, head_src_d;
    logic              head_valid_q;
    logic              grant_ok, pick0, pick1, rdy0, rdy1;
    logic              accept, acc_src, push, pop, tail_src;
    logic [DATA_W-1:0] acc_data;

    // Credit counts every word between acceptance and pop, so the FIFO can never overflow.
    assign credit_used = {1'b0, fifo_count_q} + {1'b0, inflight_q};
    assign grant_ok    = ~reset & bus.enable & (credit_used < (CNT_W+1)'(FIFO_DEPTH));

    // last_src_q names the requester granted last; on contention the other one wins.
    assign pick0 = bus.req0_valid & (~bus.req1_valid | last_src_q);
    assign pick1 = bus.req1_valid & (~bus.req0_valid | ~last_src_q);
    assign rdy0  = grant_ok & pick0;
    assign rdy1  = grant_ok & pick1;

    assign accept   = rdy0 | rdy1;
    assign acc_src  = rdy1;
    assign acc_data = rdy1 ? bus.req1_data : bus.req0_data;

    assign push     = tag_v_q[PIPE_N-1];
    assign tail_src = tag_s_q[PIPE_N-1];
    assign pop      = head_valid_q & bus.code_ready;

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.enc_datain = enc_datain_q;
    assign bus.code_valid = head_valid_q;
    assign bus.code_out   = head_code_q;
    assign bus.code_src   = head_src_q;
    assign bus.busy       = (inflight_q != '0) | (fifo_count_q != '0);

    always_comb begin
        fifo_count_d = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
        inflight_d   = inflight_q + CNT_W'(accept) - CNT_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        remain       = fifo_count_q - CNT_W'(pop);
        head_code_d  = head_code_q;
        head_src_d   = head_src_q;
        // The head register holds the last popped word while empty, keeping idle wires quiet.
        if (fifo_count_d != '0) begin
            if (remain == '0) begin
                head_code_d = bus.enc_codeout;
                head_src_d  = tail_src;
            end else begin
                head_code_d = mem_q[rd_ptr_d][23:0];
                head_src_d  = mem_q[rd_ptr_d][24];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fifo_count_q <= '0;
            inflight_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tag_v_q      <= '0;
            tag_s_q      <= '0;
            last_src_q   <= 1'b1;
            enc_datain_q <= '0;
            head_code_q  <= '0;
            head_src_q   <= 1'b0;
            head_valid_q <= 1'b0;
        end else begin
            fifo_count_q <= fifo_count_d;
            inflight_q   <= inflight_d;
            rd_ptr_q     <= rd_ptr_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            tag_v_q <= {tag_v_q[PIPE_N-2:0], accept};
            tag_s_q <= {tag_s_q[PIPE_N-2:0], acc_src};
            if (accept) begin
                enc_datain_q <= acc_data;
                last_src_q   <= acc_src;
            end
            head_code_q  <= head_code_d;
            head_src_q   <= head_src_d;
            head_valid_q <= (fifo_count_d != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {tail_src, bus.enc_codeout};
        end
    end
endmodule

// File: tb/tb_dps_link_scheduler.sv
// tb/tb_dps_link_scheduler.sv - randomized and directed bench with an acceptance-order reference model
module tb_dps_link_scheduler;
    localparam int DATA_W  = 20;
    localparam int ENC_LAT = 1;
    localparam int DEPTH   = 4;

    logic clock = 1'b0;
    logic reset;

    dps_link_scheduler_if #(.DATA_W(DATA_W)) bus_if ();

    dps_link_scheduler #(
        .DATA_W(DATA_W),
        .ENC_LAT(ENC_LAT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus_if)
    );

    always #5 clock = ~clock;

    function automatic logic [23:0] enc_f(input logic [DATA_W-1:0] x);
        return {x ^ 20'hA5A5A, 4'hC};
    endfunction

    // Encoder stand-in: fixed ENC_LAT-edge delay from enc_datain to enc_codeout.
    logic [23:0] enc_pipe [ENC_LAT];
    always @(posedge clock) begin
        enc_pipe[0] <= enc_f(bus_if.enc_datain);
        for (int i = 1; i < ENC_LAT; i++) enc_pipe[i] <= enc_pipe[i-1];
    end
    assign bus_if.enc_codeout = enc_pipe[ENC_LAT-1];

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              src;
        int                acc;
    } word_t;

    word_t             mq[$];
    int                cyc;
    logic              last_g;
    logic [23:0]       last_code;
    logic              last_src_m;
    logic [DATA_W-1:0] last_data;
    int                n_cmp, n_err;
    logic              g0, g1;
    logic              s_r0, s_r1, s_valid, s_src, s_busy;
    logic [23:0]       s_out;
    logic [23:0]       pc[$];
    logic              ps[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic v0, input logic [DATA_W-1:0] d0, input logic v1,
                        input logic [DATA_W-1:0] d1, input logic cr, input logic en, input logic rst);
        logic hv;
        logic pop;
        hv  = 1'b0;
        pop = 1'b0;
        reset               = rst;
        bus_if.enable       = en;
        bus_if.req0_valid   = v0;
        bus_if.req0_data    = d0;
        bus_if.req1_valid   = v1;
        bus_if.req1_data    = d1;
        bus_if.code_ready   = cr;
        #1;
        s_r0    = bus_if.req0_ready;
        s_r1    = bus_if.req1_ready;
        s_valid = bus_if.code_valid;
        s_out   = bus_if.code_out;
        s_src   = bus_if.code_src;
        s_busy  = bus_if.busy;
        if (rst) begin
            g0 = 1'b0;
            g1 = 1'b0;
            check("req0_ready_in_reset", s_r0, 0);
            check("req1_ready_in_reset", s_r1, 0);
        end else begin
            g0 = en && (mq.size() < DEPTH) && v0 && (!v1 || last_g);
            g1 = en && (mq.size() < DEPTH) && v1 && (!v0 || !last_g);
            hv = (mq.size() > 0) && (mq[0].acc + ENC_LAT + 2 <= cyc);
            check("req0_ready", s_r0, g0);
            check("req1_ready", s_r1, g1);
            check("code_valid", s_valid, hv);
            check("code_out", s_out, hv ? enc_f(mq[0].data) : last_code);
            check("code_src", s_src, hv ? mq[0].src : last_src_m);
            check("busy", s_busy, mq.size() != 0);
            check("enc_datain", bus_if.enc_datain, last_data);
            if (s_valid && cr) begin
                pc.push_back(s_out);
                ps.push_back(s_src);
            end
        end
        pop = !rst && hv && cr;
        @(posedge clock);
        if (rst) begin
            mq.delete();
            last_g     = 1'b1;
            last_code  = '0;
            last_src_m = 1'b0;
            last_data  = '0;
        end else begin
            if (pop) begin
                last_code  = enc_f(mq[0].data);
                last_src_m = mq[0].src;
                void'(mq.pop_front());
            end
            if (g0) begin
                mq.push_back('{d0, 1'b0, cyc});
                last_g    = 1'b0;
                last_data = d0;
            end
            if (g1) begin
                mq.push_back('{d1, 1'b1, cyc});
                last_g    = 1'b1;
                last_data = d1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n, input logic cr);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, cr, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        int i0, i1, acc, pops, dv;
        logic gl[$];
        logic [DATA_W-1:0] expd [12];
        int pv0, pv1, pcr;
        logic p0, p1, rs;
        logic [DATA_W-1:0] d0r, d1r;

        n_cmp = 0; n_err = 0; cyc = 0;
        last_g = 1'b1; last_code = '0; last_src_m = 1'b0; last_data = '0;
        reset = 1'b1;
        bus_if.enable = 1'b0; bus_if.req0_valid = 1'b0; bus_if.req1_valid = 1'b0;
        bus_if.req0_data = '0; bus_if.req1_data = '0; bus_if.code_ready = 1'b0;

        // Reset state
        do_reset();
        idle(1, 1'b1);
        check("reset_code_valid", s_valid, 0);
        check("reset_code_out", s_out, 0);
        check("reset_busy", s_busy, 0);

        // Single word, latency 3 with ENC_LAT=1
        step(1'b1, 20'd5, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("single_ready", s_r0, 1);
        idle(2, 1'b1);
        check("single_not_yet", s_valid, 0);
        idle(1, 1'b1);
        check("single_valid", s_valid, 1);
        check("single_code", s_out, 24'hA5A5FC);
        check("single_src", s_src, 0);
        idle(1, 1'b1);
        check("single_busy_drop", s_busy, 0);

        // Contention: alternate grants and ordered output
        do_reset();
        pc.delete(); ps.delete();
        i0 = 0; i1 = 0;
        for (int k = 0; k < 60 && !(i0 == 6 && i1 == 6 && mq.size() == 0); k++) begin
            step(i0 < 6, DATA_W'(1 + i0), i1 < 6, DATA_W'(11 + i1), 1'b1, 1'b1, 1'b0);
            if (s_r0) gl.push_back(1'b0);
            if (s_r1) gl.push_back(1'b1);
            if (g0) i0++;
            if (g1) i1++;
        end
        check("contention_done", (i0 == 6 && i1 == 6 && mq.size() == 0), 1);
        check("contention_grants", gl.size(), 12);
        for (int k = 0; k < 12 && k < gl.size(); k++) check("contention_grant_order", gl[k], k % 2);
        for (int k = 0; k < 6; k++) begin
            expd[2*k]   = DATA_W'(1 + k);
            expd[2*k+1] = DATA_W'(11 + k);
        end
        check("contention_out_count", pc.size(), 12);
        for (int k = 0; k < 12 && k < pc.size(); k++) begin
            check("contention_out_code", pc[k], enc_f(expd[k]));
            check("contention_out_src", ps[k], k % 2);
        end

        // Backpressure fills exactly DEPTH credits
        do_reset();
        pc.delete(); ps.delete();
        acc = 0; dv = 100;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, DATA_W'(dv), 1'b0, '0, 1'b0, 1'b1, 1'b0);
            if (s_r0) acc++;
            if (g0) dv++;
        end
        check("backpressure_accepts", acc, DEPTH);
        step(1'b1, DATA_W'(dv), 1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("full_pop_no_grant", s_r0, 0);
        step(1'b1, DATA_W'(dv), 1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("full_grant_next", s_r0, 1);
        if (g0) dv++;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, DATA_W'(dv), 1'b0, '0, 1'b1, 1'b1, 1'b0);
            if (g0) dv++;
        end
        idle(8, 1'b1);
        check("stream_count", pc.size(), dv - 100);
        for (int k = 0; k < pc.size(); k++) check("stream_order", pc[k], enc_f(DATA_W'(100 + k)));

        // Enable drop with two words in flight
        do_reset();
        pc.delete(); ps.delete();
        step(1'b1, 20'd40, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 20'd41, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 20'd42, 1'b0, '0, 1'b1, 1'b0, 1'b0);
            check("disabled_ready", s_r0, 0);
        end
        check("disabled_drain_count", pc.size(), 2);

        // Reset with three words buffered
        for (int k = 0; k < 3; k++) step(1'b1, DATA_W'(50 + k), 1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        pc.delete(); ps.delete();
        idle(1, 1'b1);
        check("midreset_code_valid", s_valid, 0);
        check("midreset_code_out", s_out, 0);
        check("midreset_busy", s_busy, 0);
        idle(6, 1'b1);
        check("midreset_no_stale", pc.size(), 0);

        // Idle hold of last codeword
        step(1'b1, 20'd7, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        idle(4, 1'b1);
        for (int k = 0; k < 10; k++) begin
            idle(1, 1'b1);
            check("idle_hold_code", s_out, 24'hA5A5DC);
            check("idle_hold_valid", s_valid, 0);
        end

        // Randomized traffic
        p0 = 1'b0; p1 = 1'b0; d0r = '0; d1r = '0;
        pv0 = 50; pv1 = 50; pcr = 50;
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0) begin
                pv0 = $urandom_range(0, 100);
                pv1 = $urandom_range(0, 100);
                pcr = $urandom_range(10, 100);
            end
            if (!p0) begin
                p0  = ($urandom_range(0, 99) < pv0);
                d0r = DATA_W'($urandom);
            end
            if (!p1) begin
                p1  = ($urandom_range(0, 99) < pv1);
                d1r = DATA_W'($urandom);
            end
            rs = ($urandom_range(0, 499) == 0);
            step(p0, d0r, p1, d1r, $urandom_range(0, 99) < pcr, $urandom_range(0, 15) != 0, rs);
            if (g0 || rs) p0 = 1'b0;
            if (g1 || rs) p1 = 1'b0;
        end
        idle(10, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
